// File: rtl/debug_trace_buffer.sv
// Trace capture buffer: arm, trigger on a PC match, then record PC/instruction pairs.
// The TRACE_OVERWRITE_EN macro makes a full buffer keep the newest samples instead of the oldest.
module debug_trace_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       stop,
    input  logic [31:0]                trig_pc,
    input  logic [31:0]                pc_in,
    input  logic [31:0]                instr_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH):0]     count,
    output logic [1:0]                 state,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          cur;
    state_t          nxt;
    logic [63:0]     mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW:0]     cnt;
    logic            ovf;
    logic            match;
    logic            push;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic            drop_oldest;

    assign match = (pc_in == trig_pc);
    assign full  = (cnt == FULL_CNT);
    assign pop   = (cnt != '0) && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // stop outranks both arm and a trigger match
    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE: begin
                if (arm && !stop) nxt = ARMED;
            end
            ARMED: begin
                if (stop)       nxt = IDLE;
                else if (match) nxt = CAPTURE;
            end
            CAPTURE: begin
                if (stop) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        push = 1'b0;
        unique case (cur)
            ARMED:   push = match && !stop;
            CAPTURE: push = !stop;
            default: push = 1'b0;
        endcase
    end

`ifdef TRACE_OVERWRITE_EN
    // a full buffer without a pop retires its oldest entry to make room
    assign wr_en       = push;
    assign drop_oldest = push && full && !pop;
`else
    assign wr_en       = push && (!full || pop);
    assign drop_oldest = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wptr] <= {pc_in, instr_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (pop || drop_oldest) begin
                rptr <= rptr + 1'b1;
            end
            if (wr_en && !drop_oldest && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (!wr_en && pop) begin
                cnt <= cnt - 1'b1;
            end
            if (push && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    assign out_valid = (cnt != '0);
    assign out_pc    = out_valid ? mem[rptr][63:32] : 32'd0;
    assign out_instr = out_valid ? mem[rptr][31:0]  : 32'd0;
    assign count     = cnt;
    assign state     = cur;
    assign overflow  = ovf;

endmodule

// File: doc/debug_trace_buffer.md
DEBUG_TRACE_BUFFER -- requirements
Module: debug_trace_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, trace entry count (power of two, >= 2).
REQ-002 SHALL provide port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port arm  input  1  one-cycle request to arm the trigger.
REQ-005 SHALL provide port stop  input  1  one-cycle request to end capture.
REQ-006 SHALL provide port trig_pc  input  32  PC value that starts capture.
REQ-007 SHALL provide port pc_in  input  32  CPU pc_debug sample.
REQ-008 SHALL provide port instr_in  input  32  CPU instruction_debug sample.
REQ-009 SHALL provide port out_valid  output  1  oldest entry available.
REQ-010 SHALL provide port out_ready  input  1  consumer accepts oldest entry.
REQ-011 SHALL provide port out_pc  output  32  PC of oldest entry, 0 when out_valid=0.
REQ-012 SHALL provide port out_instr  output  32  instruction of oldest entry, 0 when out_valid=0.
REQ-013 SHALL provide port count  output  log2(DEPTH)+1  stored entries, 0..DEPTH.
REQ-014 SHALL provide port state  output  2  IDLE=0, ARMED=1, CAPTURE=2.
REQ-015 SHALL provide port overflow  output  1  sticky flag, a sample hit a full buffer.

Function
REQ-016 SHALL implement FSM IDLE -> ARMED on arm=1; ARMED -> CAPTURE when pc_in==trig_pc; CAPTURE -> IDLE on stop=1.
REQ-017 SHALL push {pc_in,instr_in} on the ARMED->CAPTURE edge and on every CAPTURE cycle with stop=0.
REQ-018 SHALL not push the sample on the cycle stop=1; stop SHALL take priority over arm and over a trigger match.
REQ-019 SHALL ignore arm in ARMED and CAPTURE; stop in IDLE or ARMED SHALL return to IDLE.
REQ-020 SHALL be first-word-fall-through: out_valid=1 iff count>0; pop on rising edge when out_valid && out_ready.
REQ-021 SHALL make a pushed entry visible on out_* the cycle after the capturing edge (1-cycle latency).
REQ-022 SHALL keep popping allowed in any state; draining SHALL not affect FSM.
REQ-023 SHALL accept simultaneous push and pop at any count>0 with count unchanged.
REQ-024 SHALL wrap read/write pointers modulo DEPTH.
REQ-025 SHALL, when full (count==DEPTH) with no pop, set overflow=1 on a push attempt; overflow SHALL clear only on reset.

Reset
REQ-026 SHALL on reset=1 at a rising edge force state=IDLE, count=0, pointers=0, overflow=0, out_valid=0, out_pc=0, out_instr=0.
REQ-027 SHALL discard all stored entries on reset mid-capture; arm/stop/pop in the reset cycle SHALL be ignored.

Configuration
REQ-028 SHALL support macro TRACE_OVERWRITE_EN: defined -> push into full buffer without pop discards oldest entry, count stays DEPTH, overflow set; undefined -> new sample dropped, contents unchanged, overflow set.

Verification
REQ-029 SHALL verify reset: 3 cycles reset=1 -> state=0, count=0, out_valid=0, out_pc=0, overflow=0.
REQ-030 SHALL verify trigger: arm, trig_pc=0x00400008, pc_in steps 0x00400000,+4,... -> first entry out_pc=0x00400008, state=2.
REQ-031 SHALL verify stop: capture 5 cycles then stop=1 -> count=5, state=0, stop-cycle sample absent.
REQ-032 SHALL verify full, DEPTH=16, out_ready=0, 20 capture cycles -> count=16, overflow=1; oldest = first sample (macro off) or fifth sample (macro on).
REQ-033 SHALL verify simultaneous push/pop at count=16 with out_ready=1 -> count stays 16, overflow=0, entries drain in capture order.
REQ-034 SHALL verify reset mid-capture at count=7 -> next cycle count=0, out_valid=0, state=0.
